// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS-like core: instruction width, opcodes,
// instruction field positions and the fetch FSM state encoding.
package mips16_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 13;
    localparam int IMM_HI    = 6;
    localparam int IMM_LO    = 0;
    localparam int JT_HI     = 12;
    localparam int JT_LO     = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Branch displacement in bytes: sign-extended word offset shifted left by one.
    function automatic logic [15:0] branch_offset(input logic [6:0] imm7);
        return {{8{imm7[6]}}, imm7, 1'b0};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-pc selection for the instruction just accepted by decode.
// Priority: jump, then taken branch, then sequential pc+2; all arithmetic wraps at 16 bits.
module pc_next_calc
    import mips16_pkg::*;
(
    input  logic [15:0]        pc_plus2,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero,
    output logic [15:0]        next_pc
);

    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[OPCODE_HI:OPCODE_LO];

    always_comb begin
        next_pc = pc_plus2;
        if (jump) begin
            next_pc = {pc_plus2[15:14], instr[JT_HI:JT_LO], 1'b0};
        end else if (branch && zero) begin
            next_pc = pc_plus2 + branch_offset(instr[IMM_HI:IMM_LO]);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word per pc, holds it for decode, and
// steers the pc from the control unit's jump/branch/zero on each accept.
module instr_fetch
    import mips16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic [15:0]        pc_plus2,
    output logic               instr_valid,
    input  logic               dec_ready,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero,
    output logic [15:0]        retired_cnt,
    output fetch_state_t       fsm_state
);

    // Handshakes: imem_ack completes a fetch only in the cycle imem_req=1;
    // instr is consumed in the cycle instr_valid=1 and dec_ready=1 (accept).
    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  next_pc;
    logic         accept;

    assign accept      = instr_valid && dec_ready;
    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc;
    assign pc_plus2    = pc + 16'd2;
    assign opcode      = instr[OPCODE_HI:OPCODE_LO];
    assign fsm_state   = state;

    pc_next_calc u_pc_next_calc (
        .pc_plus2 (pc_plus2),
        .instr    (instr),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            retired_cnt <= 16'd0;
        end else begin
            retired_cnt <= retired_cnt + {15'd0, accept};
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                        state       <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table plus hand
// sequences for stalls, counter wrap and reset during REQ/HOLD.
module tb_instr_fetch;
    import mips16_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_ack = 1'b0;
    logic [15:0]  imem_rdata = 16'h0000;
    logic [15:0]  instr;
    logic [2:0]   opcode;
    logic [15:0]  pc_plus2;
    logic         instr_valid;
    logic         dec_ready = 1'b0;
    logic         jump = 1'b0;
    logic         branch = 1'b0;
    logic         zero = 1'b0;
    logic [15:0]  retired_cnt;
    fetch_state_t fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .retired_cnt (retired_cnt),
        .fsm_state   (fsm_state)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] rdata;
        logic        dr;
        logic        j;
        logic        b;
        logic        z;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] ins;
        logic [15:0] pp2;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic ack, input logic [15:0] rdata,
                           input logic dr, input logic j, input logic b, input logic z,
                           input logic req, input logic [15:0] addr, input logic valid,
                           input logic [15:0] ins, input logic [15:0] pp2, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.dr = dr; v.j = j; v.b = b; v.z = z;
        v.req = req; v.addr = addr; v.valid = valid; v.ins = ins; v.pp2 = pp2; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ack, input logic [15:0] rdata,
                        input logic dr, input logic j, input logic b, input logic z);
        reset = rst; imem_ack = ack; imem_rdata = rdata;
        dec_ready = dr; jump = j; branch = b; zero = z;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic req, input logic [15:0] addr,
                                 input logic valid, input logic [15:0] ins,
                                 input logic [15:0] pp2, input logic [15:0] cnt);
        logic [15:0] exp_op;
        exp_op = {13'd0, ins[15:13]};
        chk({tag, " imem_req"},    {15'd0, imem_req},    {15'd0, req});
        chk({tag, " imem_addr"},   imem_addr,            addr);
        chk({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, valid});
        chk({tag, " instr"},       instr,                ins);
        chk({tag, " opcode"},      {13'd0, opcode},      exp_op);
        chk({tag, " pc_plus2"},    pc_plus2,             pp2);
        chk({tag, " retired_cnt"}, retired_cnt,          cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //       rst ack rdata     dr j  b  z   req addr      v  instr     pc+2      cnt
        add_vec(1, 1, 16'h1234, 1, 0, 0, 0,  0, 16'h0000, 0, 16'h0000, 16'h0002, 16'd0);
        add_vec(0, 1, 16'h1111, 1, 0, 0, 0,  1, 16'h0000, 0, 16'h0000, 16'h0002, 16'd0);
        add_vec(0, 1, 16'h0001, 1, 1, 1, 1,  0, 16'h0000, 1, 16'h0001, 16'h0002, 16'd0);
        add_vec(0, 1, 16'hAAAA, 1, 0, 0, 0,  1, 16'h0002, 0, 16'h0001, 16'h0004, 16'd1);
        add_vec(0, 1, 16'h0002, 1, 0, 0, 0,  0, 16'h0002, 1, 16'h0002, 16'h0004, 16'd1);
        add_vec(0, 1, 16'hBBBB, 1, 0, 0, 0,  1, 16'h0004, 0, 16'h0002, 16'h0006, 16'd2);
        add_vec(0, 1, 16'h0003, 1, 0, 0, 0,  0, 16'h0004, 1, 16'h0003, 16'h0006, 16'd2);
        add_vec(0, 0, 16'h0000, 1, 0, 0, 0,  1, 16'h0006, 0, 16'h0003, 16'h0008, 16'd3);
        add_vec(0, 1, 16'h4008, 1, 0, 0, 0,  0, 16'h0006, 1, 16'h4008, 16'h0008, 16'd3);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 0,  1, 16'h0010, 0, 16'h4008, 16'h0012, 16'd4);
        add_vec(0, 1, 16'h4005, 1, 0, 0, 0,  0, 16'h0010, 1, 16'h4005, 16'h0012, 16'd4);
        add_vec(0, 0, 16'h0000, 1, 1, 1, 1,  1, 16'h000A, 0, 16'h4005, 16'h000C, 16'd5);
        add_vec(0, 1, 16'h4010, 1, 0, 0, 0,  0, 16'h000A, 1, 16'h4010, 16'h000C, 16'd5);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 0,  1, 16'h0020, 0, 16'h4010, 16'h0022, 16'd6);
        add_vec(0, 1, 16'h807E, 1, 0, 0, 0,  0, 16'h0020, 1, 16'h807E, 16'h0022, 16'd6);
        add_vec(0, 0, 16'h0000, 1, 0, 1, 1,  1, 16'h001E, 0, 16'h807E, 16'h0020, 16'd7);
        add_vec(0, 1, 16'h4010, 1, 0, 0, 0,  0, 16'h001E, 1, 16'h4010, 16'h0020, 16'd7);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 0,  1, 16'h0020, 0, 16'h4010, 16'h0022, 16'd8);
        add_vec(0, 1, 16'h807E, 1, 0, 0, 0,  0, 16'h0020, 1, 16'h807E, 16'h0022, 16'd8);
        add_vec(0, 0, 16'h0000, 1, 0, 1, 0,  1, 16'h0022, 0, 16'h807E, 16'h0024, 16'd9);
        add_vec(0, 1, 16'h807E, 1, 0, 0, 0,  0, 16'h0022, 1, 16'h807E, 16'h0024, 16'd9);
        add_vec(0, 0, 16'h0000, 1, 0, 0, 1,  1, 16'h0024, 0, 16'h807E, 16'h0026, 16'd10);
        add_vec(0, 1, 16'h4000, 1, 0, 0, 0,  0, 16'h0024, 1, 16'h4000, 16'h0026, 16'd10);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 0,  1, 16'h0000, 0, 16'h4000, 16'h0002, 16'd11);
        add_vec(0, 1, 16'h807E, 1, 0, 0, 0,  0, 16'h0000, 1, 16'h807E, 16'h0002, 16'd11);
        add_vec(0, 0, 16'h0000, 1, 0, 1, 1,  1, 16'hFFFE, 0, 16'h807E, 16'h0000, 16'd12);
        add_vec(0, 1, 16'h807E, 1, 0, 0, 0,  0, 16'hFFFE, 1, 16'h807E, 16'h0000, 16'd12);
        add_vec(0, 0, 16'h0000, 1, 0, 1, 1,  1, 16'hFFFC, 0, 16'h807E, 16'hFFFE, 16'd13);
        add_vec(0, 1, 16'h0000, 1, 0, 0, 0,  0, 16'hFFFC, 1, 16'h0000, 16'hFFFE, 16'd13);
        add_vec(0, 0, 16'h0000, 1, 0, 0, 0,  1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'd14);
        add_vec(0, 1, 16'h0000, 1, 0, 0, 0,  0, 16'hFFFE, 1, 16'h0000, 16'h0000, 16'd14);
        add_vec(0, 0, 16'h0000, 1, 0, 0, 0,  1, 16'h0000, 0, 16'h0000, 16'h0002, 16'd15);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].dr,
                 vecs[i].j, vecs[i].b, vecs[i].z);
            check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                          vecs[i].valid, vecs[i].ins, vecs[i].pp2, vecs[i].cnt);
            if (i == 0) chk("vec0 fsm_state", {14'd0, fsm_state}, {14'd0, ST_IDLE});
        end

        // Slow memory (3 idle cycles) and a decode stall of 4 cycles.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 16'h5555, 1, 1, 1, 1);
            check_outputs($sformatf("wait_ack%0d", k), 1, 16'h0000, 0, 16'h0000, 16'h0002, 16'd15);
        end
        step(0, 1, 16'h2ABC, 0, 0, 0, 0);
        check_outputs("ack_late", 0, 16'h0000, 1, 16'h2ABC, 16'h0002, 16'd15);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 16'hFFFF, 0, 1, 1, 1);
            check_outputs($sformatf("stall%0d", k), 0, 16'h0000, 1, 16'h2ABC, 16'h0002, 16'd15);
        end
        step(0, 0, 16'h0000, 1, 0, 0, 0);
        check_outputs("stall_release", 1, 16'h0002, 0, 16'h2ABC, 16'h0004, 16'd16);

        // Retire counter wrap from 0xFFFF.
        force dut.retired_cnt = 16'hFFFF;
        step(0, 0, 16'h0000, 1, 0, 0, 0);
        release dut.retired_cnt;
        step(0, 0, 16'h0000, 1, 0, 0, 0);
        check_outputs("wrap_preload", 1, 16'h0002, 0, 16'h2ABC, 16'h0004, 16'hFFFF);
        step(0, 1, 16'h0005, 1, 0, 0, 0);
        check_outputs("wrap_fetch", 0, 16'h0002, 1, 16'h0005, 16'h0004, 16'hFFFF);
        step(0, 0, 16'h0000, 1, 0, 0, 0);
        check_outputs("wrap_accept", 1, 16'h0004, 0, 16'h0005, 16'h0006, 16'h0000);

        // Reset while a fetch is pending, with an ack in the reset cycle.
        step(0, 1, 16'h0006, 1, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 0, 0);
        check_outputs("pre_reset", 1, 16'h0006, 0, 16'h0006, 16'h0008, 16'd1);
        step(1, 1, 16'h1357, 1, 0, 0, 0);
        check_outputs("rst_req", 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'd0);
        chk("rst_req fsm_state", {14'd0, fsm_state}, {14'd0, ST_IDLE});
        step(0, 1, 16'h2468, 1, 0, 0, 0);
        check_outputs("rst_refetch", 1, 16'h0000, 0, 16'h0000, 16'h0002, 16'd0);
        step(0, 1, 16'h0042, 0, 0, 0, 0);
        check_outputs("rst_fetched", 0, 16'h0000, 1, 16'h0042, 16'h0002, 16'd0);

        // Reset while holding an instruction: it is dropped, not retired.
        step(1, 0, 16'h0000, 1, 0, 0, 0);
        check_outputs("rst_hold", 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'd0);
        chk("rst_hold fsm_state", {14'd0, fsm_state}, {14'd0, ST_IDLE});
        step(0, 0, 16'h0000, 1, 0, 0, 0);
        check_outputs("rst_hold_refetch", 1, 16'h0000, 0, 16'h0000, 16'h0002, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
